// File: rtl/alu2_pipe.sv
// Secondary address ALU (stack, string, count and ret-imm arithmetic) followed by
// an elastic NUM_STAGES-deep result pipeline with valid/ready flow control.
module alu2_pipe #(
    parameter int DATA_W     = 32,
    parameter int NUM_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu2_op,
    input  logic [DATA_W-1:0] sr1,
    input  logic [DATA_W-1:0] sr2,
    input  logic [DATA_W-1:0] esp,
    input  logic [DATA_W-1:0] EIP_next,
    input  logic              DF_in,
    input  logic [1:0]        mem_rd_size,
    input  logic [1:0]        mem_wr_size,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_res2,
    output logic              cnt_zero,
    output logic              illegal_op
);

    localparam logic [3:0] OP_SR1  = 4'b0000;
    localparam logic [3:0] OP_SR2  = 4'b0001;
    localparam logic [3:0] OP_EIP  = 4'b0010;
    localparam logic [3:0] OP_POP  = 4'b0100;
    localparam logic [3:0] OP_STR  = 4'b0101;
    localparam logic [3:0] OP_PUSH = 4'b0110;
    localparam logic [3:0] OP_RET  = 4'b1000;
    localparam logic [3:0] OP_CNT  = 4'b1001;
    localparam int         LAST    = NUM_STAGES - 1;

    logic [DATA_W-1:0] w_rd_step;
    logic [DATA_W-1:0] w_wr_step;
    logic [DATA_W-1:0] w_res;
    logic              w_cz;
    logic              w_ill;
    logic              w_accept;

    logic [NUM_STAGES-1:0] r_vld;
    logic [NUM_STAGES-1:0] r_cz;
    logic [NUM_STAGES-1:0] r_ill;
    logic [DATA_W-1:0]     r_res [NUM_STAGES];
    logic [NUM_STAGES-1:0] w_adv;

    // Size codes 00..11 select a step of 1, 2, 4 or 8 bytes.
    assign w_rd_step = DATA_W'(1) << mem_rd_size;
    assign w_wr_step = DATA_W'(1) << mem_wr_size;

    always_comb begin
        w_res = '0;
        w_cz  = 1'b0;
        w_ill = 1'b0;
        case (alu2_op)
            OP_SR1:  w_res = sr1;
            OP_SR2:  w_res = sr2;
            OP_EIP:  w_res = EIP_next;
            OP_POP:  w_res = esp + w_rd_step;
            OP_PUSH: w_res = esp - w_wr_step;
            OP_STR:  w_res = DF_in ? (sr2 - w_rd_step) : (sr2 + w_rd_step);
            OP_RET:  w_res = esp + (w_rd_step << 1) + sr1;
            OP_CNT: begin
                w_res = sr1 - DATA_W'(1);
                w_cz  = (sr1 == DATA_W'(1));
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; the producer holds its payload until then, and ready may depend on the
    // consumer's ready combinationally. A stage advances if it or any later stage
    // is empty, or the consumer takes the last stage this cycle.
    always_comb begin
        w_adv = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_adv[i] = out_ready;
            for (int j = i; j < NUM_STAGES; j++) begin
                if (!r_vld[j]) begin
                    w_adv[i] = 1'b1;
                end
            end
        end
    end

    assign in_ready = w_adv[0] & ~rst;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_cz  <= '0;
            r_ill <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_res[i] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_vld[0] <= w_accept;
            end
            if (w_accept) begin
                r_res[0] <= w_res;
                r_cz[0]  <= w_cz;
                r_ill[0] <= w_ill;
            end
            // Payload only moves with a valid entry, so bubbles leave data untouched.
            for (int i = 1; i < NUM_STAGES; i++) begin
                if (w_adv[i]) begin
                    r_vld[i] <= r_vld[i-1];
                    if (r_vld[i-1]) begin
                        r_res[i] <= r_res[i-1];
                        r_cz[i]  <= r_cz[i-1];
                        r_ill[i] <= r_ill[i-1];
                    end
                end
            end
        end
    end

    assign out_valid  = r_vld[LAST];
    assign alu_res2   = r_res[LAST];
    assign cnt_zero   = r_cz[LAST] & r_vld[LAST];
    assign illegal_op = r_ill[LAST] & r_vld[LAST];

endmodule

// File: tb/tb_alu2_pipe.sv
// Randomized scoreboard bench for alu2_pipe: driver pushes model results into an
// expected queue, an independent monitor pops and compares on each output transfer.
module tb_alu2_pipe;

    localparam int DATA_W     = 32;
    localparam int NUM_STAGES = 2;
    localparam int W2         = DATA_W + 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu2_op;
    logic [DATA_W-1:0] sr1, sr2, esp, EIP_next;
    logic              DF_in;
    logic [1:0]        mem_rd_size, mem_wr_size;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_res2;
    logic              cnt_zero;
    logic              illegal_op;

    logic [W2-1:0] exp_q[$];
    int            lat_q[$];
    int            n_cmp;
    int            n_fail;
    int            n_out;
    int            cyc;
    int            rdy_mode;
    logic          lat_chk;
    logic          stall_seen;

    localparam logic [DATA_W-1:0] ALL1 = {DATA_W{1'b1}};

    alu2_pipe #(.DATA_W(DATA_W), .NUM_STAGES(NUM_STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu2_op(alu2_op), .sr1(sr1), .sr2(sr2), .esp(esp), .EIP_next(EIP_next),
        .DF_in(DF_in), .mem_rd_size(mem_rd_size), .mem_wr_size(mem_wr_size),
        .out_valid(out_valid), .out_ready(out_ready), .alu_res2(alu_res2),
        .cnt_zero(cnt_zero), .illegal_op(illegal_op)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, outstanding=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [W2-1:0] pk(input logic ill, input logic cz, input logic [DATA_W-1:0] r);
        return {ill, cz, r};
    endfunction

    function automatic logic [W2-1:0] model(input logic [3:0] op, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] sp,
                                            input logic [DATA_W-1:0] ip, input logic df,
                                            input logic [1:0] rs, input logic [1:0] ws);
        int unsigned       step_r;
        int unsigned       step_w;
        logic [DATA_W-1:0] r;
        step_r = 2 ** int'(rs);
        step_w = 2 ** int'(ws);
        case (int'(op))
            0:  return pk(1'b0, 1'b0, a);
            1:  return pk(1'b0, 1'b0, b);
            2:  return pk(1'b0, 1'b0, ip);
            4:  return pk(1'b0, 1'b0, sp + DATA_W'(step_r));
            5:  return pk(1'b0, 1'b0, df ? b - DATA_W'(step_r) : b + DATA_W'(step_r));
            6:  return pk(1'b0, 1'b0, sp - DATA_W'(step_w));
            8:  return pk(1'b0, 1'b0, sp + DATA_W'(2 * step_r) + a);
            9: begin
                r = a - DATA_W'(1);
                return pk(1'b0, r == '0, r);
            end
            default: return pk(1'b1, 1'b0, '0);
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] rnd_w();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    // ---------------- consumer ready ----------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic scramble();
        alu2_op     = 4'($urandom_range(0, 15));
        sr1         = rnd_w();
        sr2         = rnd_w();
        esp         = rnd_w();
        EIP_next    = rnd_w();
        DF_in       = 1'($urandom_range(0, 1));
        mem_rd_size = 2'($urandom_range(0, 3));
        mem_wr_size = 2'($urandom_range(0, 3));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic issue(input logic [3:0] op, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [DATA_W-1:0] sp, input logic [DATA_W-1:0] ip, input logic df,
                         input logic [1:0] rs, input logic [1:0] ws,
                         input logic use_exp, input logic [W2-1:0] exp_v);
        int tries;
        @(posedge clk);
        #1;
        in_valid = 1'b1; alu2_op = op; sr1 = a; sr2 = b; esp = sp; EIP_next = ip;
        DF_in = df; mem_rd_size = rs; mem_wr_size = ws;
        tries = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(use_exp ? exp_v : model(op, a, b, sp, ip, df, rs, ws));
                lat_q.push_back(lat_chk ? cyc : -1);
                break;
            end
            stall_seen = 1'b1;
            tries++;
            if (tries > 200) begin
                n_cmp++; n_fail++;
                $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, tries);
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_rand();
        logic [DATA_W-1:0] a;
        a = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 2)) : rnd_w();
        issue(4'($urandom_range(0, 15)), a, rnd_w(), rnd_w(), rnd_w(), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, '0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            idle();
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: outstanding=%0d, required 0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic              hold_v;
        logic [W2-1:0]     hold_d;
        logic [W2-1:0]     got;
        logic [W2-1:0]     e;
        int                t0;
        hold_v = 1'b0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_v = 1'b0;
                continue;
            end
            got = {illegal_op, cnt_zero, alu_res2};
            if (hold_v) begin
                n_cmp++;
                if (!out_valid || got !== hold_d) begin
                    n_fail++;
                    $display("FAIL hold: valid=%0b data=%h, required valid=1 data=%h", out_valid, got, hold_d);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, required no output", got);
                end else begin
                    e  = exp_q.pop_front();
                    t0 = lat_q.pop_front();
                    n_out++;
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL result: got ill=%0b cz=%0b res=%h, required ill=%0b cz=%0b res=%h",
                                 got[W2-1], got[W2-2], got[DATA_W-1:0], e[W2-1], e[W2-2], e[DATA_W-1:0]);
                    end
                    if (t0 >= 0) begin
                        n_cmp++;
                        if (cyc - t0 != NUM_STAGES) begin
                            n_fail++;
                            $display("FAIL latency: got %0d cycles, required %0d", cyc - t0, NUM_STAGES);
                        end
                    end
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = got;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int out0;
        int nfl;
        n_cmp = 0; n_fail = 0; n_out = 0;
        rdy_mode = 0; lat_chk = 1'b0; stall_seen = 1'b0;
        rst = 1'b1; in_valid = 1'b1;
        scramble();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        n_cmp++;
        if (alu_res2 !== '0) begin
            n_fail++;
            $display("FAIL rst_res: got %h, required 0", alu_res2);
        end
        check1("rst_cnt_zero", cnt_zero, 1'b0);
        check1("rst_illegal", illegal_op, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check1("ready_after_rst", in_ready, 1'b1);

        // Directed cases, isolated so latency is exact.
        lat_chk = 1'b1;
        issue(4'b0110, rnd_w(), rnd_w(), DATA_W'(32'h1000), rnd_w(), 1'b0, 2'b00, 2'b10, 1'b1, pk(0, 0, DATA_W'(32'h0FFC)));
        idle(); idle();
        issue(4'b0100, rnd_w(), rnd_w(), DATA_W'(32'h1000), rnd_w(), 1'b0, 2'b01, 2'b11, 1'b1, pk(0, 0, DATA_W'(32'h1002)));
        idle(); idle();
        issue(4'b0101, rnd_w(), DATA_W'(32'h200), rnd_w(), rnd_w(), 1'b0, 2'b00, 2'b01, 1'b1, pk(0, 0, DATA_W'(32'h201)));
        issue(4'b0101, rnd_w(), DATA_W'(32'h200), rnd_w(), rnd_w(), 1'b1, 2'b00, 2'b01, 1'b1, pk(0, 0, DATA_W'(32'h1FF)));
        issue(4'b1001, DATA_W'(1), rnd_w(), rnd_w(), rnd_w(), 1'b0, 2'b11, 2'b11, 1'b1, pk(0, 1, '0));
        issue(4'b1001, '0, rnd_w(), rnd_w(), rnd_w(), 1'b0, 2'b11, 2'b11, 1'b1, pk(0, 0, ALL1));
        issue(4'b0110, rnd_w(), rnd_w(), '0, rnd_w(), 1'b0, 2'b10, 2'b00, 1'b1, pk(0, 0, ALL1));
        issue(4'b1000, DATA_W'(32'h8), rnd_w(), DATA_W'(32'h100), rnd_w(), 1'b0, 2'b01, 2'b00, 1'b1, pk(0, 0, DATA_W'(32'h10C)));
        issue(4'b1111, rnd_w(), rnd_w(), rnd_w(), rnd_w(), 1'b0, 2'b01, 2'b10, 1'b1, pk(1, 0, '0));
        issue(4'b0010, rnd_w(), rnd_w(), rnd_w(), DATA_W'(32'hCAFE), 1'b0, 2'b00, 2'b00, 1'b1, pk(0, 0, DATA_W'(32'hCAFE)));
        drain();
        lat_chk = 1'b0;

        // Back-pressure: six back-to-back ops with the consumer stalled mid-burst.
        out0 = n_out;
        stall_seen = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) issue_rand();
            end
            begin
                repeat (3) @(posedge clk);
                rdy_mode = 2;
                repeat (5) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();
        check1("bp_in_ready_fell", stall_seen, 1'b1);
        n_cmp++;
        if (n_out - out0 != 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results, required 6", n_out - out0);
        end

        // Reset with results in flight: they must never emerge.
        rdy_mode = 2;
        repeat (2) idle();
        nfl = (NUM_STAGES > 1) ? 2 : 1;
        for (int k = 0; k < nfl; k++) issue_rand();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        check1("midrst_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        check1("midrst_out_valid", out_valid, 1'b0);
        repeat (6) idle();

        // Random traffic with random consumer stalls and input gaps.
        rdy_mode = 1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) idle();
            issue_rand();
        end
        rdy_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu2_pipe.md
ALU2_PIPE -- requirements
Module: alu2_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, meaning datapath width in bits (legal 16..64).
REQ-002 SHALL provide parameter NUM_STAGES, default 2, meaning pipeline depth and fixed latency in cycles (legal 1..4).
REQ-003 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  operation request present.
REQ-006 SHALL provide port in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-007 SHALL provide port alu2_op  input  4  operation select.
REQ-008 SHALL provide ports sr1, sr2, esp, EIP_next  input  DATA_W  operands.
REQ-009 SHALL provide port DF_in  input  1  string direction flag.
REQ-010 SHALL provide ports mem_rd_size, mem_wr_size  input  2  operand size codes.
REQ-011 SHALL provide port out_valid  output  1  result present at last stage.
REQ-012 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-013 SHALL provide port alu_res2  output  DATA_W  result.
REQ-014 SHALL provide port cnt_zero  output  1  result equals zero for op 1001, else 0.
REQ-015 SHALL provide port illegal_op  output  1  op not in table, qualified by out_valid.

Function
REQ-016 SHALL define step(s) = 1, 2, 4, 8 for s = 00, 01, 10, 11.
REQ-017 SHALL compute: 0000 -> sr1; 0001 -> sr2; 0010 -> EIP_next.
REQ-018 SHALL compute: 0100 (pop) -> esp + step(mem_rd_size); 0110 (push) -> esp - step(mem_wr_size).
REQ-019 SHALL compute: 0101 (string) -> sr2 + step(mem_rd_size) if DF_in=0, sr2 - step(mem_rd_size) if DF_in=1.
REQ-020 SHALL compute: 1000 (ret imm) -> esp + 2*step(mem_rd_size) + sr1.
REQ-021 SHALL compute: 1001 (count) -> sr1 - 1, cnt_zero=1 iff result is 0.
REQ-022 SHALL, for any other op, produce alu_res2=0, cnt_zero=0, illegal_op=1.
REQ-023 SHALL perform all arithmetic modulo 2^DATA_W; carries/borrows discarded (wrap, no flag).
REQ-024 SHALL compute result combinationally from inputs in the accept cycle and carry it through NUM_STAGES registered stages; each stage holds valid, result, cnt_zero, illegal_op.
REQ-025 SHALL advance a stage when it is empty or the next stage advances; last stage advances when out_ready=1 or out_valid=0.
REQ-026 SHALL drive in_ready = first stage advances (combinational, depends on out_ready through the chain).
REQ-027 SHALL give latency exactly NUM_STAGES cycles from acceptance to out_valid with no back-pressure, sustaining one op per cycle.
REQ-028 SHALL hold alu_res2, cnt_zero, illegal_op stable while out_valid=1 and out_ready=0.
REQ-029 SHALL drop nothing and duplicate nothing: results emerge in acceptance order, one per accepted request.
REQ-030 SHALL ignore operand inputs when in_valid=0 or in_ready=0.
REQ-031 SHALL, with pipeline full and out_ready low-to-high in a cycle with in_valid=1, accept the new request in that same cycle.

Reset
REQ-032 SHALL clear all stage valid bits, alu_res2, cnt_zero, illegal_op to 0 on any clock edge with rst=1.
REQ-033 SHALL drive in_ready=0 while rst=1 and discard in-flight results when rst asserts mid-operation.
REQ-034 SHALL accept requests from the first cycle after rst deasserts.

Verification
REQ-035 SHALL cover push/pop sizes: esp=0x1000, op 0110 with mem_wr_size=10 -> 0x00000FFC; op 0100 with mem_rd_size=01 -> 0x00001002, each out_valid after NUM_STAGES cycles.
REQ-036 SHALL cover string direction: sr2=0x200, op 0101, mem_rd_size=00, DF_in=0 -> 0x201; DF_in=1 -> 0x1FF.
REQ-037 SHALL cover wrap and count: op 1001, sr1=1 -> 0, cnt_zero=1; op 1001, sr1=0 -> 0xFFFFFFFF, cnt_zero=0; op 0110, esp=0, size 00 -> 0xFFFFFFFF.
REQ-038 SHALL cover back-pressure: 6 back-to-back ops, out_ready=0 for cycles 3-7 -> in_ready falls once NUM_STAGES results held, outputs stable, all 6 results delivered in order.
REQ-039 SHALL cover ret imm and illegal: esp=0x100, sr1=0x8, size 01, op 1000 -> 0x10C; op 1111 -> alu_res2=0, illegal_op=1.
REQ-040 SHALL cover reset mid-flight: rst=1 for one cycle with 2 ops in flight -> out_valid=0 next cycle, neither result ever appears.
